// File: rtl/rls_err_monitor.sv
// ---------------------------------------------------------------------------
// rls_err_monitor
//
// Purpose:
//   Watches the a-priori error stream of the RLS adaptive filter. It averages
//   the squared error over fixed windows of 2**LOG2_WIN accepted samples and
//   produces a windowed mean-squared error. From that MSE it tracks lock:
//   CONV_WINDOWS consecutive good windows declare convergence, and any window
//   above the divergence threshold latches a sticky divergence flag that only
//   Rst or clear can release.
//
// Ports:
//   Clk          in   1      clock, rising edge
//   Rst          in   1      asynchronous reset, active-high
//   clear        in   1      synchronous clear, same effect as Rst, top priority
//   enable       in   1      1 = monitor running, 0 = return to IDLE
//   err_in       in   WIDTH  signed Q4.12 error sample
//   err_valid    in   1      err_in carries a sample this cycle
//   mse_thresh   in   WIDTH  unsigned Q4.12 convergence threshold
//   div_thresh   in   WIDTH  unsigned Q4.12 divergence threshold
//   mse_out      out  WIDTH  MSE of the last completed window, saturated
//   mse_valid    out  1      one-cycle pulse when mse_out updates
//   converged    out  1      high while in CONVERGED
//   diverged     out  1      high while in DIVERGED
//   conv_sample  out  CNT_W  accepted-sample count at the latest convergence
//   state_out    out  2      0 IDLE, 1 TRACK, 2 CONVERGED, 3 DIVERGED
// ---------------------------------------------------------------------------
module rls_err_monitor #(
    parameter int WIDTH        = 16,
    parameter int FRAC         = 12,
    parameter int LOG2_WIN     = 4,
    parameter int CONV_WINDOWS = 3,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] err_in,
    input  logic             err_valid,
    input  logic [WIDTH-1:0] mse_thresh,
    input  logic [WIDTH-1:0] div_thresh,
    output logic [WIDTH-1:0] mse_out,
    output logic             mse_valid,
    output logic             converged,
    output logic             diverged,
    output logic [CNT_W-1:0] conv_sample,
    output logic [1:0]       state_out
);

    // Squared sample after dropping FRAC bits; a full window of these summed
    // needs LOG2_WIN extra bits so the accumulator can never wrap.
    localparam int SQ_W   = 2*WIDTH - FRAC;
    localparam int ACC_W  = SQ_W + LOG2_WIN;
    localparam int GOOD_W = $clog2(CONV_WINDOWS + 1);
    localparam logic [WIDTH-1:0] MSE_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRACK     = 2'd1,
        CONVERGED = 2'd2,
        DIVERGED  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LOG2_WIN-1:0] winCnt_q, winCnt_d;
    logic [GOOD_W-1:0]  goodCnt_q, goodCnt_d;
    logic [CNT_W-1:0]   sampCnt_q, sampCnt_d;
    logic [WIDTH-1:0]   mseOut_q, mseOut_d;
    logic               mseValid_q, mseValid_d;
    logic [CNT_W-1:0]   convSample_q, convSample_d;
    logic               converged_q, diverged_q;

    logic signed [2*WIDTH-1:0] sq;
    logic [SQ_W-1:0]    sqQ;
    logic [ACC_W-1:0]   accSum;
    logic [SQ_W-1:0]    mseFull;
    logic [WIDTH-1:0]   mse;
    logic               accepted;
    logic               winEnd;
    logic [CNT_W-1:0]   sampInc;
    logic [GOOD_W-1:0]  goodInc;

    // The square of a two's complement value is never negative, so the
    // arithmetic shift result always fits in SQ_W unsigned bits.
    assign sq      = $signed(err_in) * $signed(err_in);
    assign sqQ     = SQ_W'(sq >>> FRAC);
    assign accSum  = acc_q + {{LOG2_WIN{1'b0}}, sqQ};
    assign mseFull = accSum[ACC_W-1:LOG2_WIN];
    assign mse     = (mseFull > {{(SQ_W-WIDTH){1'b0}}, MSE_MAX}) ? MSE_MAX : mseFull[WIDTH-1:0];

    // Dropping enable wins over a coincident sample, so a sample only counts
    // while the monitor is running and still enabled.
    assign accepted = err_valid && enable && (state_q == TRACK || state_q == CONVERGED);
    assign winEnd   = accepted && (winCnt_q == {LOG2_WIN{1'b1}});
    assign sampInc  = (sampCnt_q == {CNT_W{1'b1}}) ? sampCnt_q : sampCnt_q + 1'b1;
    assign goodInc  = goodCnt_q + 1'b1;

    // Next-state and datapath decisions. Window-end decisions check divergence
    // first, then the convergence threshold; only TRACK counts good windows.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        winCnt_d     = winCnt_q;
        goodCnt_d    = goodCnt_q;
        sampCnt_d    = sampCnt_q;
        mseOut_d     = mseOut_q;
        mseValid_d   = 1'b0;
        convSample_d = convSample_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = TRACK;
                end
            end
            TRACK, CONVERGED: begin
                if (!enable) begin
                    state_d   = IDLE;
                    acc_d     = '0;
                    winCnt_d  = '0;
                    goodCnt_d = '0;
                end else if (accepted) begin
                    sampCnt_d = sampInc;
                    acc_d     = accSum;
                    winCnt_d  = winCnt_q + 1'b1;
                    if (winEnd) begin
                        acc_d      = '0;
                        winCnt_d   = '0;
                        mseOut_d   = mse;
                        mseValid_d = 1'b1;
                        if (mse > div_thresh) begin
                            state_d = DIVERGED;
                        end else if (mse <= mse_thresh) begin
                            if (state_q == TRACK) begin
                                goodCnt_d = goodInc;
                                if (goodInc == GOOD_W'(CONV_WINDOWS)) begin
                                    state_d      = CONVERGED;
                                    convSample_d = sampInc;
                                end
                            end
                        end else begin
                            goodCnt_d = '0;
                            state_d   = TRACK;
                        end
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State and output registers. The lock flags are decoded from the next
    // state so they change on the same edge that raises mse_valid.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            winCnt_q     <= '0;
            goodCnt_q    <= '0;
            sampCnt_q    <= '0;
            mseOut_q     <= '0;
            mseValid_q   <= 1'b0;
            convSample_q <= '0;
            converged_q  <= 1'b0;
            diverged_q   <= 1'b0;
        end else if (clear) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            winCnt_q     <= '0;
            goodCnt_q    <= '0;
            sampCnt_q    <= '0;
            mseOut_q     <= '0;
            mseValid_q   <= 1'b0;
            convSample_q <= '0;
            converged_q  <= 1'b0;
            diverged_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            winCnt_q     <= winCnt_d;
            goodCnt_q    <= goodCnt_d;
            sampCnt_q    <= sampCnt_d;
            mseOut_q     <= mseOut_d;
            mseValid_q   <= mseValid_d;
            convSample_q <= convSample_d;
            converged_q  <= (state_d == CONVERGED);
            diverged_q   <= (state_d == DIVERGED);
        end
    end

    assign mse_out     = mseOut_q;
    assign mse_valid   = mseValid_q;
    assign converged   = converged_q;
    assign diverged    = diverged_q;
    assign conv_sample = convSample_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_rls_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_rls_err_monitor
//
// Purpose:
//   Self-checking bench for rls_err_monitor with 4-sample windows and two
//   good windows to lock. Directed scenarios hit the documented cases; a
//   randomized phase compares every output each cycle against a reference
//   model that keeps the current window as a queue of squared samples.
// ---------------------------------------------------------------------------
module tb_rls_err_monitor;

    localparam int WIDTH = 16;
    localparam int LOG2_WIN = 2;
    localparam int CONV_WINDOWS = 2;
    localparam int CNT_W = 16;

    logic              Clk;
    logic              Rst;
    logic              clear;
    logic              enable;
    logic [WIDTH-1:0]  err_in;
    logic              err_valid;
    logic [WIDTH-1:0]  mse_thresh;
    logic [WIDTH-1:0]  div_thresh;
    logic [WIDTH-1:0]  mse_out;
    logic              mse_valid;
    logic              converged;
    logic              diverged;
    logic [CNT_W-1:0]  conv_sample;
    logic [1:0]        state_out;

    int passed = 0;
    int total = 0;

    // Reference model state: state as a plain number, window as a queue.
    int mState;
    int mWin[$];
    int mSamp;
    int mGood;
    int expMse;
    int expValid;
    int expConvSample;

    rls_err_monitor #(
        .WIDTH(WIDTH), .FRAC(12), .LOG2_WIN(LOG2_WIN),
        .CONV_WINDOWS(CONV_WINDOWS), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Rst(Rst), .clear(clear), .enable(enable),
        .err_in(err_in), .err_valid(err_valid),
        .mse_thresh(mse_thresh), .div_thresh(div_thresh),
        .mse_out(mse_out), .mse_valid(mse_valid),
        .converged(converged), .diverged(diverged),
        .conv_sample(conv_sample), .state_out(state_out)
    );

    // Free-running 10-unit clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Return the model to its power-on picture.
    task automatic modelReset();
        mState = 0;
        mWin.delete();
        mSamp = 0;
        mGood = 0;
        expMse = 0;
        expValid = 0;
        expConvSample = 0;
    endtask

    // Advance the model by one clock edge with the given inputs, using the
    // documented rules directly: mean of the window's squares, thresholds,
    // and lock counting.
    task automatic modelStep(input bit clr, input bit en, input bit v, input logic [15:0] e);
        int se, sq, sum, mse;
        if (clr) begin
            modelReset();
            return;
        end
        expValid = 0;
        if (mState == 0) begin
            if (en) mState = 1;
        end else if (mState == 1 || mState == 2) begin
            if (!en) begin
                mState = 0;
                mWin.delete();
                mGood = 0;
            end else if (v) begin
                se = int'($signed(e));
                sq = (se * se) >>> 12;
                mWin.push_back(sq);
                if (mSamp < 65535) mSamp++;
                if (mWin.size() == (1 << LOG2_WIN)) begin
                    sum = 0;
                    foreach (mWin[i]) sum += mWin[i];
                    mse = sum / (1 << LOG2_WIN);
                    if (mse > 32767) mse = 32767;
                    mWin.delete();
                    expMse = mse;
                    expValid = 1;
                    if (mse > int'(div_thresh)) begin
                        mState = 3;
                    end else if (mse <= int'(mse_thresh)) begin
                        if (mState == 1) begin
                            mGood++;
                            if (mGood == CONV_WINDOWS) begin
                                mState = 2;
                                expConvSample = mSamp;
                            end
                        end
                    end else begin
                        mGood = 0;
                        mState = 1;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of inputs, step the model, and settle just past the edge.
    task automatic applyStimulus(input bit v, input logic [15:0] e, input bit en, input bit clr);
        err_valid = v;
        err_in = e;
        enable = en;
        clear = clr;
        modelStep(clr, en, v, e);
        @(posedge Clk);
        #1;
    endtask

    // Everything must read zero under reset, including across a clock edge.
    task automatic test_reset();
        Rst = 1'b1;
        clear = 1'b0;
        enable = 1'b1;
        err_valid = 1'b1;
        err_in = 16'h1000;
        mse_thresh = 16'h0100;
        div_thresh = 16'h4000;
        modelReset();
        @(posedge Clk);
        #1;
        total++; if ({mse_out, mse_valid, converged, diverged, conv_sample, state_out} !== '0)
            $display("[TB] FAIL reset_outputs: got mse=%h v=%b c=%b d=%b cs=%0d st=%0d want all zero",
                     mse_out, mse_valid, converged, diverged, conv_sample, state_out);
        else passed++;
        Rst = 1'b0;
        applyStimulus(0, 16'h0, 1, 0);
        total++; if (state_out !== 2'd1) $display("[TB] FAIL idle_to_track: got %0d want 1", state_out);
        else passed++;
    endtask

    // Four samples of 1.0 give an MSE of 1.0 with a single-cycle valid pulse.
    task automatic test_window_mse();
        for (int i = 0; i < 3; i++) applyStimulus(1, 16'h1000, 1, 0);
        total++; if (mse_valid !== 1'b0) $display("[TB] FAIL early_valid: got %b want 0", mse_valid);
        else passed++;
        applyStimulus(1, 16'h1000, 1, 0);
        total++; if (mse_out !== 16'h1000) $display("[TB] FAIL win_mse: got %h want 1000", mse_out);
        else passed++;
        total++; if (mse_valid !== 1'b1) $display("[TB] FAIL win_valid: got %b want 1", mse_valid);
        else passed++;
        applyStimulus(0, 16'h0, 1, 0);
        total++; if (mse_valid !== 1'b0) $display("[TB] FAIL valid_pulse_width: got %b want 0", mse_valid);
        else passed++;
        total++; if (mse_out !== 16'h1000) $display("[TB] FAIL mse_hold: got %h want 1000", mse_out);
        else passed++;
    endtask

    // Negative errors square positive; 0x0400 is above the lock threshold.
    task automatic test_negative();
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'hF800, 1, 0);
        total++; if (mse_out !== 16'h0400) $display("[TB] FAIL neg_mse: got %h want 0400", mse_out);
        else passed++;
        total++; if (state_out !== 2'd1) $display("[TB] FAIL neg_state: got %0d want 1", state_out);
        else passed++;
    endtask

    // Full-scale errors saturate the MSE and latch divergence.
    task automatic test_saturate_diverge();
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'h7FFF, 1, 0);
        total++; if (mse_out !== 16'h7FFF) $display("[TB] FAIL sat_mse: got %h want 7fff", mse_out);
        else passed++;
        total++; if (diverged !== 1'b1 || state_out !== 2'd3)
            $display("[TB] FAIL diverge: got d=%b st=%0d want d=1 st=3", diverged, state_out);
        else passed++;
        for (int i = 0; i < 5; i++) applyStimulus(1, 16'h0100, 1, 0);
        total++; if (mse_valid !== 1'b0 || state_out !== 2'd3 || mse_out !== 16'h7FFF)
            $display("[TB] FAIL div_sticky: got v=%b st=%0d mse=%h want v=0 st=3 mse=7fff",
                     mse_valid, state_out, mse_out);
        else passed++;
    endtask

    // After clear, two good windows lock the monitor at sample 8.
    task automatic test_convergence();
        applyStimulus(0, 16'h0, 1, 1);
        total++; if (state_out !== 2'd0 || diverged !== 1'b0 || mse_out !== 16'h0)
            $display("[TB] FAIL clear: got st=%0d d=%b mse=%h want 0 0 0", state_out, diverged, mse_out);
        else passed++;
        applyStimulus(0, 16'h0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'h0100, 1, 0);
        total++; if (mse_out !== 16'h0010 || converged !== 1'b0)
            $display("[TB] FAIL conv_win1: got mse=%h c=%b want 0010 0", mse_out, converged);
        else passed++;
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'h0100, 1, 0);
        total++; if (converged !== 1'b1 || state_out !== 2'd2 || mse_valid !== 1'b1)
            $display("[TB] FAIL conv_lock: got c=%b st=%0d v=%b want 1 2 1", converged, state_out, mse_valid);
        else passed++;
        total++; if (conv_sample !== 16'd8) $display("[TB] FAIL conv_sample: got %0d want 8", conv_sample);
        else passed++;
    endtask

    // A bad window while locked drops back to TRACK, keeping conv_sample.
    task automatic test_loss_of_lock();
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'h1000, 1, 0);
        total++; if (converged !== 1'b0 || state_out !== 2'd1 || mse_out !== 16'h1000)
            $display("[TB] FAIL lock_loss: got c=%b st=%0d mse=%h want 0 1 1000", converged, state_out, mse_out);
        else passed++;
        total++; if (conv_sample !== 16'd8) $display("[TB] FAIL lock_loss_cs: got %0d want 8", conv_sample);
        else passed++;
    endtask

    // Async reset mid-window must wipe the partial sum.
    task automatic test_reset_midwindow();
        applyStimulus(1, 16'h7FFF, 1, 0);
        applyStimulus(1, 16'h7FFF, 1, 0);
        err_valid = 1'b0;
        #2;
        Rst = 1'b1;
        modelReset();
        #1;
        total++; if ({mse_out, mse_valid, converged, diverged, conv_sample, state_out} !== '0)
            $display("[TB] FAIL async_reset: got mse=%h cs=%0d st=%0d want all zero", mse_out, conv_sample, state_out);
        else passed++;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        applyStimulus(0, 16'h0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'h0800, 1, 0);
        total++; if (mse_out !== 16'h0400) $display("[TB] FAIL post_reset_mse: got %h want 0400", mse_out);
        else passed++;
    endtask

    // Dropping enable discards the partial window and the good-window count
    // but keeps counting samples toward conv_sample.
    task automatic test_enable_drop();
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'h0100, 1, 0);
        applyStimulus(1, 16'h7000, 1, 0);
        applyStimulus(1, 16'h7000, 1, 0);
        applyStimulus(1, 16'h7000, 0, 0);
        total++; if (state_out !== 2'd0 || mse_out !== 16'h0010)
            $display("[TB] FAIL en_drop: got st=%0d mse=%h want 0 0010", state_out, mse_out);
        else passed++;
        applyStimulus(1, 16'h7000, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'h0100, 1, 0);
        total++; if (mse_out !== 16'h0010 || state_out !== 2'd1)
            $display("[TB] FAIL en_no_stale: got mse=%h st=%0d want 0010 1", mse_out, state_out);
        else passed++;
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'h0100, 1, 0);
        total++; if (state_out !== 2'd2 || conv_sample !== 16'd18)
            $display("[TB] FAIL en_relock: got st=%0d cs=%0d want 2 18", state_out, conv_sample);
        else passed++;
    endtask

    // Random traffic, thresholds, enable drops and clears, every output
    // compared against the model each cycle.
    task automatic test_random();
        int r;
        logic [15:0] e;
        bit v, en, clr;
        applyStimulus(0, 16'h0, 1, 1);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            clr = ($urandom_range(0, 59) == 0);
            if (clr) begin
                mse_thresh = 16'($urandom_range(16'h0008, 16'h0400));
                div_thresh = 16'($urandom_range(16'h0800, 16'h7FFF));
            end
            en = ($urandom_range(0, 24) != 0);
            v = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 9) < 8) begin
                r = int'($urandom_range(0, 1023)) - 512;
                e = r[15:0];
            end else begin
                e = 16'($urandom);
            end
            applyStimulus(v, e, en, clr);
            total++; if (int'(mse_out) !== expMse) $display("[TB] FAIL rand_mse @%0d: got %h want %h", cyc, mse_out, expMse);
            else passed++;
            total++; if (int'(mse_valid) !== expValid) $display("[TB] FAIL rand_valid @%0d: got %b want %0d", cyc, mse_valid, expValid);
            else passed++;
            total++; if (int'(state_out) !== mState) $display("[TB] FAIL rand_state @%0d: got %0d want %0d", cyc, state_out, mState);
            else passed++;
            total++; if (converged !== (mState == 2)) $display("[TB] FAIL rand_conv @%0d: got %b want %b", cyc, converged, mState == 2);
            else passed++;
            total++; if (diverged !== (mState == 3)) $display("[TB] FAIL rand_div @%0d: got %b want %b", cyc, diverged, mState == 3);
            else passed++;
            total++; if (int'(conv_sample) !== expConvSample) $display("[TB] FAIL rand_cs @%0d: got %0d want %0d", cyc, conv_sample, expConvSample);
            else passed++;
        end
    endtask

    // Scenario sequence; the directed cases build on one another's state.
    initial begin
        test_reset();
        test_window_mse();
        test_negative();
        test_saturate_diverge();
        test_convergence();
        test_loss_of_lock();
        test_reset_midwindow();
        test_enable_drop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
